temporal_ngram_encoder: RTL and testbench



---
 rtl/temporal_ngram_encoder.sv | 139 +++++++++++++
 tb/tb_temporal_ngram_encoder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/temporal_ngram_encoder.sv
// Temporal N-gram encoder: per-modality permute-and-XOR over the last NGRAM samples, folded
// one history entry per cycle. Optional macro NGRAM_EMIT_PARTIAL_EN emits warm-up N-grams.

`ifndef HV_DIMENSION
`define HV_DIMENSION 64
`endif

module temporal_ngram_encoder #(
  parameter int unsigned NGRAM      = 3,
  parameter int unsigned DIM        = `HV_DIMENSION,
  parameter int unsigned FILL_WIDTH = $clog2(NGRAM + 1),
  parameter int unsigned IDX_WIDTH  = (NGRAM > 1) ? $clog2(NGRAM) : 1
) (
  input  logic           Clk_CI,
  input  logic           Reset_RI,
  input  logic           ValidIn_SI,
  output logic           ReadyOut_SO,
  input  logic [0:DIM-1] HypervectorIn_mod1_DI,
  input  logic [0:DIM-1] HypervectorIn_mod2_DI,
  input  logic [0:DIM-1] HypervectorIn_mod3_DI,
  output logic           ValidOut_SO,
  input  logic           ReadyIn_SI,
  output logic [0:DIM-1] HypervectorOut_mod1_DO,
  output logic [0:DIM-1] HypervectorOut_mod2_DO,
  output logic [0:DIM-1] HypervectorOut_mod3_DO
);

  localparam int unsigned NumMod = 3;

  localparam logic [1:0] S_IDLE          = 2'd0;
  localparam logic [1:0] S_FOLD          = 2'd1;
  localparam logic [1:0] S_OUTPUT_STABLE = 2'd2;

  logic [1:0]            r_state;
  logic [FILL_WIDTH-1:0] r_fill;
  logic [IDX_WIDTH-1:0]  r_idx;
  logic [0:DIM-1]        r_hist [NumMod][NGRAM];
  logic [0:DIM-1]        r_acc  [NumMod];

  logic [0:DIM-1]        w_in       [NumMod];
  logic [0:DIM-1]        w_hist_nxt [NumMod][NGRAM];
  logic [FILL_WIDTH-1:0] w_fill_nxt;
  logic                  w_start_fold;

  // rho: out[0] = in[DIM-1], out[k] = in[k-1]
  function automatic logic [0:DIM-1] rho(input logic [0:DIM-1] x);
    return {x[DIM-1], x[0:DIM-2]};
  endfunction

  assign w_in[0] = HypervectorIn_mod1_DI;
  assign w_in[1] = HypervectorIn_mod2_DI;
  assign w_in[2] = HypervectorIn_mod3_DI;

  always_comb begin
    w_fill_nxt = (r_fill == FILL_WIDTH'(NGRAM)) ? r_fill : r_fill + 1'b1;
`ifdef NGRAM_EMIT_PARTIAL_EN
    w_start_fold = 1'b1;
`else
    w_start_fold = (w_fill_nxt == FILL_WIDTH'(NGRAM));
`endif
  end

  always_comb begin
    for (int m = 0; m < NumMod; m++) begin
      w_hist_nxt[m][0] = w_in[m];
      for (int i = 1; i < NGRAM; i++) begin
        w_hist_nxt[m][i] = r_hist[m][i-1];
      end
`ifdef NGRAM_EMIT_PARTIAL_EN
      // Warm-up samples fill from the oldest slot, so the first one is rotated NGRAM-1 times
      // and the window lines up with the shifting order once full.
      if (32'(r_fill) < NGRAM) begin
        for (int i = 0; i < NGRAM; i++) begin
          if (i == int'(NGRAM) - 1 - int'(r_fill)) begin
            w_hist_nxt[m][i] = w_in[m];
          end else begin
            w_hist_nxt[m][i] = r_hist[m][i];
          end
        end
      end
`endif
    end
  end

  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      r_state <= S_IDLE;
      r_fill  <= '0;
      r_idx   <= '0;
      for (int m = 0; m < NumMod; m++) begin
        r_acc[m] <= '0;
        for (int i = 0; i < NGRAM; i++) begin
          r_hist[m][i] <= '0;
        end
      end
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (ValidIn_SI) begin
            for (int m = 0; m < NumMod; m++) begin
              r_acc[m] <= '0;
              for (int i = 0; i < NGRAM; i++) begin
                r_hist[m][i] <= w_hist_nxt[m][i];
              end
            end
            r_idx  <= IDX_WIDTH'(NGRAM - 1);
            r_fill <= w_fill_nxt;
            if (w_start_fold) begin
              r_state <= S_FOLD;
            end
          end
        end
        S_FOLD: begin
          for (int m = 0; m < NumMod; m++) begin
            r_acc[m] <= rho(r_acc[m]) ^ r_hist[m][r_idx];
          end
          if (r_idx == '0) begin
            r_state <= S_OUTPUT_STABLE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        S_OUTPUT_STABLE: begin
          if (ReadyIn_SI) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ReadyOut_SO            = (r_state == S_IDLE);
  assign ValidOut_SO            = (r_state == S_OUTPUT_STABLE);
  assign HypervectorOut_mod1_DO = r_acc[0];
  assign HypervectorOut_mod2_DO = r_acc[1];
  assign HypervectorOut_mod3_DO = r_acc[2];

endmodule

// File: tb/tb_temporal_ngram_encoder.sv
// Bench for temporal_ngram_encoder (NGRAM=3, default build): directed table plus random
// samples against a sliding-window reference model.

module tb_temporal_ngram_encoder;

  localparam int NGRAM = 3;
  localparam int DIM   = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           valid_in = 1'b0;
  logic           ready_out;
  logic [0:DIM-1] in1 = '0, in2 = '0, in3 = '0;
  logic           valid_out;
  logic           ready_in = 1'b1;
  logic [0:DIM-1] out1, out2, out3;

  int n_checks = 0;
  int n_fail   = 0;

  temporal_ngram_encoder #(.NGRAM(NGRAM), .DIM(DIM)) dut (
    .Clk_CI                (clk),
    .Reset_RI              (rst),
    .ValidIn_SI            (valid_in),
    .ReadyOut_SO           (ready_out),
    .HypervectorIn_mod1_DI (in1),
    .HypervectorIn_mod2_DI (in2),
    .HypervectorIn_mod3_DI (in3),
    .ValidOut_SO           (valid_out),
    .ReadyIn_SI            (ready_in),
    .HypervectorOut_mod1_DO(out1),
    .HypervectorOut_mod2_DO(out2),
    .HypervectorOut_mod3_DO(out3)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_bit(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_vec(input string nm, input logic [0:DIM-1] act, input logic [0:DIM-1] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: window of the last NGRAM samples, newest first.
  logic [0:DIM-1] mh [3][NGRAM];
  int             mfill;

  function automatic logic [0:DIM-1] rotr(input logic [0:DIM-1] x, input int k);
    logic [0:DIM-1] y;
    for (int j = 0; j < DIM; j++) y[(j + k) % DIM] = x[j];
    return y;
  endfunction

  function automatic logic [0:DIM-1] onehot(input int k);
    logic [0:DIM-1] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [0:DIM-1] rand_hv();
    logic [0:DIM-1] v;
    for (int j = 0; j < DIM; j++) v[j] = 1'($urandom);
    return v;
  endfunction

  task automatic model_reset();
    mfill = 0;
    for (int m = 0; m < 3; m++)
      for (int i = 0; i < NGRAM; i++) mh[m][i] = '0;
  endtask

  task automatic model_push(input logic [0:DIM-1] a, b, c);
    for (int m = 0; m < 3; m++)
      for (int i = NGRAM - 1; i > 0; i--) mh[m][i] = mh[m][i-1];
    mh[0][0] = a;
    mh[1][0] = b;
    mh[2][0] = c;
    if (mfill < NGRAM) mfill++;
  endtask

  function automatic logic [0:DIM-1] model_out(input int m);
    logic [0:DIM-1] r;
    r = '0;
    for (int i = 0; i < NGRAM; i++) r ^= rotr(mh[m][i], i);
    return r;
  endfunction

  task automatic apply_reset();
    #2 rst = 1'b1;
    #1;
    check_bit("rst_valid_out", valid_out, 1'b0);
    check_bit("rst_ready_out", ready_out, 1'b1);
    check_vec("rst_out1", out1, '0);
    check_vec("rst_out2", out2, '0);
    check_vec("rst_out3", out3, '0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Sends one sample, checks it against the model, optionally holds the output for `hold` cycles.
  task automatic send(input logic [0:DIM-1] a, b, c, input int hold,
                      output logic got_v, output logic [0:DIM-1] g1, g2, g3);
    int             n;
    int             lat;
    logic           exp_v;
    logic [0:DIM-1] s1, s2, s3;
    got_v = 1'b0;
    g1 = '0; g2 = '0; g3 = '0;
    n = 0;
    @(negedge clk);
    while (!ready_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_bit("ready_wait", ready_out, 1'b1);
    if (!ready_out) return;
    ready_in = (hold == 0);
    valid_in = 1'b1;
    in1 = a; in2 = b; in3 = c;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    in1 = rand_hv(); in2 = rand_hv(); in3 = rand_hv();
    model_push(a, b, c);
    exp_v = (mfill == NGRAM);
    lat = 0;
    repeat (NGRAM + 4) begin
      @(negedge clk);
      if (valid_out) begin
        got_v = 1'b1;
        break;
      end
      lat++;
    end
    check_bit("valid_out", got_v, exp_v);
    if (exp_v && got_v) begin
      check_int("latency", lat, NGRAM);
      check_bit("ready_out_busy", ready_out, 1'b0);
      check_vec("out1", out1, model_out(0));
      check_vec("out2", out2, model_out(1));
      check_vec("out3", out3, model_out(2));
    end
    if (!exp_v) check_bit("warmup_ready", ready_out, 1'b1);
    g1 = out1; g2 = out2; g3 = out3;
    if (got_v && hold > 0) begin
      s1 = out1; s2 = out2; s3 = out3;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        valid_in = 1'($urandom);
        in1 = rand_hv(); in2 = rand_hv(); in3 = rand_hv();
        @(negedge clk);
        check_bit("hold_valid", valid_out, 1'b1);
        check_bit("hold_ready", ready_out, 1'b0);
        check_bit("hold_stable", (out1 === s1) && (out2 === s2) && (out3 === s3), 1'b1);
      end
      valid_in = 1'b0;
    end
    ready_in = 1'b1;
    if (got_v) @(posedge clk);
  endtask

  typedef struct {
    bit             do_rst;
    logic [0:DIM-1] i1, i2, i3;
    int             hold;
    bit             ev;
    logic [0:DIM-1] x1, x2, x3;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic           gv;
    logic [0:DIM-1] g1, g2, g3;
    logic [0:DIM-1] e0, e012, e12, e02, elast, m2x, ones;

    e0    = onehot(0);
    e012  = onehot(0) | onehot(1) | onehot(2);
    e12   = onehot(1) | onehot(2);
    e02   = onehot(0) | onehot(2);
    elast = onehot(DIM - 1);
    m2x   = onehot(DIM - 1) | onehot(0) | onehot(1);
    ones  = '1;

    tbl[0] = '{1'b1, e0, e0, e0, 0, 1'b0, '0, '0, '0};
    tbl[1] = '{1'b0, e0, e0, e0, 0, 1'b0, '0, '0, '0};
    tbl[2] = '{1'b0, e0, e0, e0, 0, 1'b1, e012, e012, e012};
    tbl[3] = '{1'b0, '0, '0, '0, 20, 1'b1, e12, e12, e12};
    tbl[4] = '{1'b0, e0, e0, e0, 0, 1'b1, e02, e02, e02};
    tbl[5] = '{1'b1, e0, elast, ones, 0, 1'b0, '0, '0, '0};
    tbl[6] = '{1'b0, e0, elast, ones, 0, 1'b0, '0, '0, '0};
    tbl[7] = '{1'b0, e0, elast, ones, 0, 1'b1, e012, m2x, ones};

    model_reset();
    #1;
    check_bit("init_valid_out", valid_out, 1'b0);
    check_bit("init_ready_out", ready_out, 1'b1);
    check_vec("init_out1", out1, '0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 8; k++) begin
      if (tbl[k].do_rst) apply_reset();
      send(tbl[k].i1, tbl[k].i2, tbl[k].i3, tbl[k].hold, gv, g1, g2, g3);
      check_bit($sformatf("tbl%0d_valid", k), gv, tbl[k].ev);
      if (tbl[k].ev) begin
        check_vec($sformatf("tbl%0d_out1", k), g1, tbl[k].x1);
        check_vec($sformatf("tbl%0d_out2", k), g2, tbl[k].x2);
        check_vec($sformatf("tbl%0d_out3", k), g3, tbl[k].x3);
      end
    end

    // Asynchronous reset in the middle of a fold.
    apply_reset();
    send(e0, e0, e0, 0, gv, g1, g2, g3);
    send(e0, e0, e0, 0, gv, g1, g2, g3);
    @(negedge clk);
    valid_in = 1'b1;
    in1 = e0; in2 = e0; in3 = e0;
    @(posedge clk);
    #1 valid_in = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_bit("midfold_valid_out", valid_out, 1'b0);
    check_bit("midfold_ready_out", ready_out, 1'b1);
    check_vec("midfold_out1", out1, '0);
    check_vec("midfold_out3", out3, '0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      send(rand_hv(), rand_hv(), rand_hv(), 0, gv, g1, g2, g3);
      check_bit($sformatf("post_rst%0d_valid", k), gv, (k == 2));
    end

    // Random samples with random backpressure.
    for (int k = 0; k < 40; k++) begin
      send(rand_hv(), rand_hv(), rand_hv(), int'($urandom_range(0, 3)), gv, g1, g2, g3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
